// File: rtl/demux1_2_pipe.sv
// Registered 1-to-2 demux: in_sel steers each accepted beat into one of two 2-entry FIFOs.
// Latency: a beat accepted at edge k is visible at outN in cycle k+1 (no comb in->out path).
// Backpressure: in_ready = !full of the selected channel (registered occupancy only, no pass-through).
// Ports:
//   clk, reset_n                    - clock, async active-low reset (discards all queued beats)
//   in_valid/in_ready/in_sel/in_data - input stream, in_sel picks channel 0 or 1
//   outN_valid/outN_ready/outN_data  - per-channel output stream, data is the FIFO head
//   cnt0, cnt1                       - wrapping count of beats delivered per channel
module demux1_2_pipe #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  // Per-channel state, index 0/1 = channel.
  logic [WIDTH-1:0] mem    [2][2];
  logic             wr_ptr [2];
  logic             rd_ptr [2];
  logic [1:0]       occ    [2];
  logic [CNT_W-1:0] cnt    [2];

  logic       accept;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_valid;
  logic [1:0] out_ready;

  assign out_ready = {out1_ready, out0_ready};

  // A full channel refuses the push even if it pops this cycle.
  assign in_ready = in_sel ? (occ[1] != 2'd2) : (occ[0] != 2'd2);
  assign accept   = in_valid && in_ready;
  assign push[0]  = accept && !in_sel;
  assign push[1]  = accept &&  in_sel;

  assign out_valid[0] = (occ[0] != 2'd0);
  assign out_valid[1] = (occ[1] != 2'd0);
  assign pop          = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        mem[c][0] <= '0;
        mem[c][1] <= '0;
        wr_ptr[c] <= 1'b0;
        rd_ptr[c] <= 1'b0;
        occ[c]    <= 2'd0;
        cnt[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= in_data;
          wr_ptr[c]         <= ~wr_ptr[c];
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
          cnt[c]    <= cnt[c] + CNT_W'(1);
        end
        // Push+pop together leaves occupancy unchanged.
        occ[c] <= occ[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      end
    end
  end

  assign out0_valid = out_valid[0];
  assign out1_valid = out_valid[1];
  assign out0_data  = mem[0][rd_ptr[0]];
  assign out1_data  = mem[1][rd_ptr[1]];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux1_2_pipe.sv
// Directed bench for demux1_2_pipe: reset, steering, full/backpressure,
// simultaneous push/pop, counter wrap and mid-operation async reset.
module tb_demux1_2_pipe;

  localparam int WIDTH = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int tests_run    = 0;
  int tests_failed = 0;

  demux1_2_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with garbage on the inputs.
    in_valid   = 1'b1;
    in_sel     = 1'b1;
    in_data    = 64'hDEAD_BEEF_0BAD_F00D;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    step();
    chk("rst_out0_valid", out0_valid, 0);
    chk("rst_out1_valid", out1_valid, 0);
    chk("rst_out0_data",  out0_data, 0);
    chk("rst_out1_data",  out1_data, 0);
    chk("rst_cnt0",       cnt0, 0);
    chk("rst_cnt1",       cnt1, 0);
    chk("rst_in_ready_s1", in_ready, 1);
    in_sel = 1'b0;
    #1;
    chk("rst_in_ready_s0", in_ready, 1);

    // Release, idle for 5 cycles.
    reset_n  = 1'b1;
    in_valid = 1'b0;
    repeat (5) step();
    chk("idle_out0_valid", out0_valid, 0);
    chk("idle_out1_valid", out1_valid, 0);
    chk("idle_cnt0",       cnt0, 0);
    chk("idle_cnt1",       cnt1, 0);

    // Steering: A->0, B->1, C->0, both consumers ready.
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'hA;
    step();
    chk("steer_a_valid0", out0_valid, 1);
    chk("steer_a_data0",  out0_data, 64'hA);
    chk("steer_a_valid1", out1_valid, 0);
    in_sel = 1'b1; in_data = 64'hB;
    step();
    chk("steer_b_valid0", out0_valid, 0);
    chk("steer_b_cnt0",   cnt0, 1);
    chk("steer_b_valid1", out1_valid, 1);
    chk("steer_b_data1",  out1_data, 64'hB);
    in_sel = 1'b0; in_data = 64'hC;
    step();
    chk("steer_c_valid0", out0_valid, 1);
    chk("steer_c_data0",  out0_data, 64'hC);
    chk("steer_c_valid1", out1_valid, 0);
    chk("steer_c_cnt1",   cnt1, 1);
    in_valid = 1'b0;
    step();
    chk("steer_end_valid0", out0_valid, 0);
    chk("steer_end_cnt0",   cnt0, 2);
    chk("steer_end_cnt1",   cnt1, 1);

    // Full / backpressure on channel 0.
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 64'h1;
    #1;
    chk("full_rdy_1", in_ready, 1);
    step();
    in_data = 64'h2;
    #1;
    chk("full_rdy_2", in_ready, 1);
    step();
    in_data = 64'h3;
    #1;
    chk("full_rdy_3", in_ready, 0);
    chk("full_head_1", out0_data, 64'h1);
    in_sel = 1'b1;
    #1;
    chk("full_rdy_other", in_ready, 1);
    in_sel = 1'b0;
    out0_ready = 1'b1;
    #1;
    chk("full_no_passthru", in_ready, 0);
    step();  // pops 0x1, 0x3 refused
    chk("full_head_2",   out0_data, 64'h2);
    chk("full_cnt0_3",   cnt0, 3);
    chk("full_rdy_again", in_ready, 1);
    step();  // pops 0x2, pushes 0x3
    chk("full_head_3",  out0_data, 64'h3);
    chk("full_valid_3", out0_valid, 1);
    in_valid = 1'b0;
    step();  // pops 0x3
    chk("full_drained", out0_valid, 0);
    chk("full_cnt0_5",  cnt0, 5);

    // Simultaneous push/pop on channel 1 at occupancy 1.
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 64'h10;
    step();
    chk("pp_head_10", out1_data, 64'h10);
    in_data = 64'h11;
    out1_ready = 1'b1;
    #1;
    chk("pp_rdy", in_ready, 1);
    step();
    chk("pp_head_11",  out1_data, 64'h11);
    chk("pp_valid_11", out1_valid, 1);
    chk("pp_cnt1",     cnt1, 2);
    in_valid = 1'b0;
    out1_ready = 1'b0;
    step();
    chk("pp_hold_valid", out1_valid, 1);
    chk("pp_hold_data",  out1_data, 64'h11);
    out1_ready = 1'b1;
    step();
    // Only one entry was queued, so one pop empties it.
    chk("pp_empty", out1_valid, 0);
    chk("pp_cnt1_3", cnt1, 3);

    // Counter wrap: 256 pops on channel 1 starting from cnt1=3.
    in_valid = 1'b1; in_sel = 1'b1; in_data = 64'd0;
    step();
    for (int i = 1; i < 256; i++) begin
      in_data = 64'(i);
      step();
      if (i == 252) begin
        chk("wrap_cnt1_255", cnt1, 255);
        chk("wrap_head_252", out1_data, 64'd252);
      end
      if (i == 253) begin
        chk("wrap_cnt1_0",   cnt1, 0);
        chk("wrap_head_253", out1_data, 64'd253);
      end
    end
    in_valid = 1'b0;
    step();
    chk("wrap_cnt1_end", cnt1, 3);
    chk("wrap_empty1",   out1_valid, 0);
    chk("wrap_cnt0",     cnt0, 5);

    // Mid-operation async reset with both FIFOs full.
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 1'b0; in_data = 64'hAA; step();
    in_data = 64'hBB; step();
    in_sel = 1'b1; in_data = 64'hCC; step();
    in_data = 64'hDD; step();
    in_valid = 1'b0;
    chk("mr_full1", in_ready, 0);
    in_sel = 1'b0;
    #1;
    chk("mr_full0", in_ready, 0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_valid0_drop", out0_valid, 0);
    chk("mr_valid1_drop", out1_valid, 0);
    chk("mr_data0",       out0_data, 0);
    chk("mr_cnt0",        cnt0, 0);
    chk("mr_in_ready",    in_ready, 1);
    #1;
    reset_n = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    repeat (3) step();
    chk("mr_after_valid0", out0_valid, 0);
    chk("mr_after_valid1", out1_valid, 0);
    chk("mr_after_cnt0",   cnt0, 0);
    chk("mr_after_cnt1",   cnt1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
